// File: rtl/alu_exec_pkg.sv
// Shared ALU opcode constants (as emitted by the ALU control decoder) and FSM encodings.
// Optional overflow detection is built only when ALU_OVF_EN is defined.
package alu_exec_pkg;

  localparam int unsigned ALUC_W = 4;

  localparam logic [ALUC_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [ALUC_W-1:0] ALU_ADDU = 4'h1;
  localparam logic [ALUC_W-1:0] ALU_SUB  = 4'h2;
  localparam logic [ALUC_W-1:0] ALU_SUBU = 4'h3;
  localparam logic [ALUC_W-1:0] ALU_AND  = 4'h4;
  localparam logic [ALUC_W-1:0] ALU_OR   = 4'h5;
  localparam logic [ALUC_W-1:0] ALU_XOR  = 4'h6;
  localparam logic [ALUC_W-1:0] ALU_NOR  = 4'h7;
  localparam logic [ALUC_W-1:0] ALU_SLT  = 4'h8;
  localparam logic [ALUC_W-1:0] ALU_SLTU = 4'h9;
  localparam logic [ALUC_W-1:0] ALU_SLL  = 4'hA;
  localparam logic [ALUC_W-1:0] ALU_SRL  = 4'hB;
  localparam logic [ALUC_W-1:0] ALU_SRA  = 4'hC;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic is_shift(input logic [ALUC_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Issue/result handshake bundle between ID/EX, the execute ALU and EX/MEM.
interface alu_exec_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5,
  parameter int unsigned TAGW  = 5
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic [TAGW-1:0]  tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [TAGW-1:0]  out_tag;
  logic             ovf;

  modport master (
    output in_valid, aluc, a, b, shamt, tag, flush, out_ready,
    input  in_ready, out_valid, result, out_tag, ovf
  );

  modport slave (
    input  in_valid, aluc, a, b, shamt, tag, flush, out_ready,
    output in_ready, out_valid, result, out_tag, ovf
  );

endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath; shift ops pass b through (the zero-shift case).
// Signed overflow is produced only when ALU_OVF_EN is defined, otherwise tied low.
module alu_comb
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [ALUC_W-1:0] aluc,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  result,
  output logic              ovf
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result = '0;
    case (aluc)
      ALU_ADD, ALU_ADDU: result = sum;
      ALU_SUB, ALU_SUBU: result = diff;
      ALU_AND:           result = a & b;
      ALU_OR:            result = a | b;
      ALU_XOR:           result = a ^ b;
      ALU_NOR:           result = ~(a | b);
      ALU_SLT:           result = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU:          result = WIDTH'(a < b);
      ALU_SLL, ALU_SRL, ALU_SRA: result = b;
      default:           result = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  // Overflow: same-sign add flipping sign, or differing-sign subtract leaving a's sign.
  always_comb begin
    ovf = 1'b0;
    if (aluc == ALU_ADD)
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (aluc == ALU_SUB)
      ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle execute ALU: single-cycle ops via alu_comb, shifts one bit per cycle.
// Overflow reporting depends on ALU_OVF_EN (see alu_comb).
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5,
  parameter int unsigned TAGW  = 5
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic              out_valid_q;
  logic [WIDTH-1:0]  result_q;
  logic [TAGW-1:0]   tag_q;
  logic              ovf_q;
  logic [WIDTH-1:0]  work;
  logic [WIDTH-1:0]  shifted;
  logic [SHW-1:0]    cnt;
  logic [ALUC_W-1:0] sop;
  logic [WIDTH-1:0]  comb_result;
  logic              comb_ovf;
  logic              accept;
  logic              start_shift;
  logic              last_shift;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .aluc   (bus.aluc),
    .a      (bus.a),
    .b      (bus.b),
    .result (comb_result),
    .ovf    (comb_ovf)
  );

  assign bus.in_ready  = !bus.flush && ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_tag   = tag_q;
  assign bus.ovf       = ovf_q;

  assign accept      = bus.in_valid && bus.in_ready;
  assign start_shift = accept && is_shift(bus.aluc) && (bus.shamt != '0);
  assign last_shift  = (state == ST_SHIFT) && (cnt == SHW'(1));

  // One-bit step of the working register for the latched shift kind.
  always_comb begin
    shifted = work;
    case (sop)
      ALU_SLL: shifted = {work[WIDTH-2:0], 1'b0};
      ALU_SRL: shifted = {1'b0, work[WIDTH-1:1]};
      default: shifted = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state_nx = start_shift ? ST_SHIFT : ST_DONE;
        ST_SHIFT: if (last_shift) state_nx = ST_DONE;
        ST_DONE: begin
          if (accept)             state_nx = start_shift ? ST_SHIFT : ST_DONE;
          else if (bus.out_ready) state_nx = ST_IDLE;
        end
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nx;
      out_valid_q <= (state_nx == ST_DONE);
    end
  end

  // Result/tag capture and the shift engine; accept already excludes flush cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      tag_q    <= '0;
      ovf_q    <= 1'b0;
      work     <= '0;
      cnt      <= '0;
      sop      <= '0;
    end else if (accept) begin
      tag_q <= bus.tag;
      if (start_shift) begin
        work  <= bus.b;
        cnt   <= bus.shamt;
        sop   <= bus.aluc;
        ovf_q <= 1'b0;
      end else begin
        result_q <= comb_result;
        ovf_q    <= comb_ovf;
      end
    end else if ((state == ST_SHIFT) && !bus.flush) begin
      work <= shifted;
      cnt  <= cnt - SHW'(1);
      if (last_shift) result_q <= shifted;
    end
  end

endmodule
